// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg : shared encodings for the shared-memory arbiter slice.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Widths sized for the legal maxima of MEM_LAT (7) and STARVE_MAX (15).
  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

  typedef enum logic {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } arb_state_t;

  typedef enum logic {
    OWNER_I = OWN_I,
    OWNER_D = OWN_D
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/rr_starve_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_starve_cnt : saturating count of D grants while I waits; forces I.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_starve_cnt
  import riscv_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_grant,
  input  logic i_grant,
  output logic force_i
);

  logic [STARVE_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_grant || !i_req) begin
      r_count <= '0;
    end else if (d_grant && (r_count != STARVE_W'(STARVE_MAX))) begin
      r_count <= r_count + STARVE_W'(1);
    end
  end

  assign force_i = i_req && (r_count == STARVE_W'(STARVE_MAX));

endmodule
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_arbiter : fixed-priority (D over I) single-port mem share. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t       r_state;
  owner_t           r_owner;
  logic [LAT_W-1:0] r_lat_cnt;

  logic w_resp;
  logic w_can_issue;
  logic w_force;
  logic w_grant_d;
  logic w_grant_i;

  // The response cycle doubles as an issue slot so back-to-back traffic overlaps.
  assign w_resp      = (r_state == WAIT) && (r_lat_cnt == LAT_W'(1));
  assign w_can_issue = !reset && ((r_state == IDLE) || w_resp);
  assign w_grant_d   = w_can_issue && d_req && !w_force;
  assign w_grant_i   = w_can_issue && i_req && !w_grant_d;

  rr_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .d_grant(w_grant_d),
    .i_grant(w_grant_i),
    .force_i(w_force)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= OWNER_I;
      r_lat_cnt <= '0;
    end else if (w_grant_d || w_grant_i) begin
      r_state   <= WAIT;
      r_owner   <= w_grant_d ? OWNER_D : OWNER_I;
      r_lat_cnt <= LAT_W'(MEM_LAT);
    end else if (r_state == WAIT) begin
      if (w_resp) begin
        r_state <= IDLE;
      end
      r_lat_cnt <= r_lat_cnt - LAT_W'(1);
    end
  end

  assign i_gnt = w_grant_i;
  assign d_gnt = w_grant_d;

  assign mem_en    = w_grant_d || w_grant_i;
  assign mem_we    = w_grant_d && d_we;
  assign mem_wstrb = w_grant_d ? d_wstrb : {STRB_W{1'b0}};
  assign mem_wdata = w_grant_d ? d_wdata : {DATA_W{1'b0}};
  assign mem_addr  = w_grant_d ? d_addr :
                     w_grant_i ? i_addr : {ADDR_W{1'b0}};

  // Reset gating keeps a mid-WAIT abort from leaking a response pulse.
  assign i_rvalid = !reset && w_resp && (r_owner == OWNER_I);
  assign d_rvalid = !reset && w_resp && (r_owner == OWNER_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign busy     = !reset && (r_state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_mem_arbiter : directed bench over MEM_LAT = 2, 1 and 4.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_riscv_mem_arbiter;

  logic clk;
  logic [2:0]       dut_reset;
  logic [2:0]       i_req, i_gnt, i_rvalid;
  logic [2:0][31:0] i_addr, i_rdata;
  logic [2:0]       d_req, d_we, d_gnt, d_rvalid;
  logic [2:0][3:0]  d_wstrb, mem_wstrb;
  logic [2:0][31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]       mem_en, mem_we, busy;
  logic [2:0][31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] init_word(input logic [7:0] k);
    return {8'hA0 ^ k, k, 8'h5C, ~k};
  endfunction

  // Instance 0: MEM_LAT=2, instance 1: MEM_LAT=1, instance 2: MEM_LAT=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [31:0] mem  [0:255];
    logic [31:0] pipe [0:LAT-1];

    riscv_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(3)
    ) u_dut (
      .clk      (clk),
      .reset    (dut_reset[g]),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_gnt    (i_gnt[g]),
      .i_rvalid (i_rvalid[g]),
      .i_rdata  (i_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_wstrb  (d_wstrb[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_wstrb(mem_wstrb[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );

    initial begin
      for (int k = 0; k < 256; k++) mem[k] = init_word(k[7:0]);
      for (int k = 0; k < LAT; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
      if (mem_en[g]) begin
        pipe[0] <= mem[mem_addr[g][9:2]];
        if (mem_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[g][b]) mem[mem_addr[g][9:2]][8*b +: 8] = mem_wdata[g][8*b +: 8];
        end
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign mem_rdata[g] = pipe[LAT-1];
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [17:0] seq;
    clk = 1'b0;
    dut_reset = '1;
    i_req = '0; i_addr = '0;
    d_req = '0; d_we = '0; d_wstrb = '0; d_addr = '0; d_wdata = '0;

    // Test 1: reset with fetch pending (inst 0, MEM_LAT=2)
    i_req[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      check("rst_i_gnt", i_gnt[0], 0);
      check("rst_mem_en", mem_en[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_mem_addr", mem_addr[0], 0);
    end
    tick(); dut_reset = '0; #1;
    check("t1_i_gnt", i_gnt[0], 1);
    check("t1_mem_en", mem_en[0], 1);
    check("t1_mem_addr", mem_addr[0], 32'h0);
    tick(); i_req[0] = 1'b0; #1;
    check("t1_busy", busy[0], 1);
    check("t1_rvalid_early", i_rvalid[0], 0);
    tick(); #1;
    check("t1_rvalid", i_rvalid[0], 1);
    check("t1_rdata", i_rdata[0], 32'hA0005CFF);
    tick(); #1;
    check("t1_rvalid_after", i_rvalid[0], 0);
    check("t1_busy_after", busy[0], 0);

    // Test 4: store then overlapping load of same word (inst 0)
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_wstrb[0] = 4'b0011;
    d_addr[0] = 32'h40; d_wdata[0] = 32'hDEADBEEF; #1;
    check("t4_d_gnt", d_gnt[0], 1);
    check("t4_mem_we", mem_we[0], 1);
    check("t4_mem_wstrb", mem_wstrb[0], 4'b0011);
    check("t4_mem_wdata", mem_wdata[0], 32'hDEADBEEF);
    check("t4_mem_addr", mem_addr[0], 32'h40);
    tick(); d_req[0] = 1'b0; #1;
    check("t4_rvalid_early", d_rvalid[0], 0);
    tick(); d_req[0] = 1'b1; d_we[0] = 1'b0; d_wstrb[0] = 4'b0000; #1;
    check("t4_st_done", d_rvalid[0], 1);
    check("t4_ld_gnt_overlap", d_gnt[0], 1);
    check("t4_ld_mem_we", mem_we[0], 0);
    tick(); d_req[0] = 1'b0; #1;
    check("t4_ld_rvalid_early", d_rvalid[0], 0);
    tick(); #1;
    w = init_word(8'd16);
    check("t4_ld_rvalid", d_rvalid[0], 1);
    check("t4_ld_rdata", d_rdata[0], {w[31:16], 16'hBEEF});

    // Test 6: idle gap, then same-cycle grant (inst 0)
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      check("t6_gap_mem_en", mem_en[0], 0);
      check("t6_gap_busy", busy[0], 0);
    end
    tick(); i_req[0] = 1'b1; i_addr[0] = 32'hC; #1;
    check("t6_i_gnt", i_gnt[0], 1);
    check("t6_mem_addr", mem_addr[0], 32'hC);
    check("t6_mem_we", mem_we[0], 0);
    tick(); i_req[0] = 1'b0; #1;
    tick(); #1;
    check("t6_rvalid", i_rvalid[0], 1);
    check("t6_rdata", i_rdata[0], init_word(8'd3));
    check("t6_d_rvalid", d_rvalid[0], 0);

    // Test 2: simultaneous requests (inst 1, MEM_LAT=1)
    tick();
    i_req[1] = 1'b1; i_addr[1] = 32'h10;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h80; #1;
    check("t2_d_gnt", d_gnt[1], 1);
    check("t2_i_gnt", i_gnt[1], 0);
    check("t2_mem_addr_d", mem_addr[1], 32'h80);
    tick(); d_req[1] = 1'b0; #1;
    check("t2_d_rvalid", d_rvalid[1], 1);
    check("t2_d_rdata", d_rdata[1], init_word(8'd32));
    check("t2_i_gnt_c1", i_gnt[1], 1);
    check("t2_mem_addr_i", mem_addr[1], 32'h10);
    check("t2_i_rvalid_c1", i_rvalid[1], 0);
    tick(); i_req[1] = 1'b0; #1;
    check("t2_i_rvalid", i_rvalid[1], 1);
    check("t2_i_rdata", i_rdata[1], init_word(8'd4));
    check("t2_d_rvalid_c2", d_rvalid[1], 0);

    // Test 3: starvation forcing, expected {d_gnt,i_gnt} per cycle
    seq = 18'b10_10_10_01_10_10_10_01_10;
    tick();
    i_req[1] = 1'b1; i_addr[1] = 32'h20;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h84; #1;
    for (int k = 0; k < 9; k++) begin
      check("t3_grant_order", {d_gnt[1], i_gnt[1]}, seq[17-2*k -: 2]);
      tick(); #1;
    end
    i_req[1] = 1'b0; d_req[1] = 1'b0;

    // Test 5: reset mid-WAIT (inst 2, MEM_LAT=4)
    tick(); i_req[2] = 1'b1; i_addr[2] = 32'h8; #1;
    check("t5_i_gnt", i_gnt[2], 1);
    tick(); i_req[2] = 1'b0; #1;
    check("t5_busy", busy[2], 1);
    tick(); #1;
    tick(); dut_reset[2] = 1'b1; #1;
    check("t5_rst_rvalid", i_rvalid[2], 0);
    check("t5_rst_busy", busy[2], 0);
    tick(); dut_reset[2] = 1'b0; #1;
    check("t5_busy_after", busy[2], 0);
    for (int c = 0; c < 5; c++) begin
      check("t5_no_rvalid", i_rvalid[2], 0);
      tick(); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
